// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: three-channel DVI TMDS encoder (ch0=b with sync, ch1=g, ch2=r), 2-cycle latency.
// Defining DVI_ENC_INPUT_REG_EN adds a stage-0 input register (3-cycle latency).
module dvi_tmds_encoder #(
  parameter int CNT_W = 5
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       de,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic [9:0] tmds_ch0,
  output logic [9:0] tmds_ch1,
  output logic [9:0] tmds_ch2
);
  logic       s0_de, s0_vs, s0_hs;
  logic [7:0] s0_r, s0_g, s0_b;
`ifdef DVI_ENC_INPUT_REG_EN
  logic [26:0] in_d, in_q;
  always_comb in_d = reset_n ? {de, vsync, hsync, r, g, b} : '0;
  always_ff @(posedge pixel_clk) in_q <= in_d;
  assign {s0_de, s0_vs, s0_hs, s0_r, s0_g, s0_b} = in_q;
`else
  assign {s0_de, s0_vs, s0_hs, s0_r, s0_g, s0_b} = {de, vsync, hsync, r, g, b};
`endif
  logic [2:0] ctl_d, ctl_q;
  always_comb ctl_d = reset_n ? {s0_de, s0_vs, s0_hs} : 3'b000;
  always_ff @(posedge pixel_clk) ctl_q <= ctl_d;
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [7:0]              d, m;
    logic [1:0]              ctrl;
    logic                    x;
    logic [8:0]              q_m_d, q_m_q;
    logic signed [CNT_W-1:0] diff, cnt_n, cnt_d, cnt_q;
    logic [9:0]              sym, tmds_d, tmds_q;
    assign d    = c == 0 ? s0_b : c == 1 ? s0_g : s0_r;
    assign ctrl = c == 0 ? ctl_q[1:0] : 2'b00;
    // XNOR chain equals the prefix parity of d inverted on every odd bit
    always_comb begin
      x = $countones(d) > 4 || ($countones(d) == 4 && !d[0]);
      for (int i = 0; i < 8; i++) m[i] = ^(d & (8'hFF >> (7 - i))) ^ (x & (i % 2 == 1));
      q_m_d = reset_n ? {~x, m} : '0;
    end
    always_comb begin
      diff  = CNT_W'(2 * $countones(q_m_q[7:0]) - 8);
      cnt_n = '0;
      sym   = ctrl == 2'b00 ? 10'h354 : ctrl == 2'b01 ? 10'h0AB : ctrl == 2'b10 ? 10'h154 : 10'h2AB;
      if (!ctl_q[2]) begin
        cnt_n = '0;
      end else if (cnt_q == 0 || diff == 0) begin
        sym   = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
        cnt_n = q_m_q[8] ? cnt_q + diff : cnt_q - diff;
      end else if ((cnt_q > 0 && diff > 0) || (cnt_q < 0 && diff < 0)) begin
        sym   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
        cnt_n = cnt_q - diff + (q_m_q[8] ? CNT_W'(2) : CNT_W'(0));
      end else begin
        sym   = {1'b0, q_m_q[8], q_m_q[7:0]};
        cnt_n = cnt_q + diff - (q_m_q[8] ? CNT_W'(0) : CNT_W'(2));
      end
      tmds_d = reset_n ? sym : 10'h354;
      cnt_d  = reset_n ? cnt_n : '0;
    end
    always_ff @(posedge pixel_clk) begin
      q_m_q  <= q_m_d;
      cnt_q  <= cnt_d;
      tmds_q <= tmds_d;
    end
  end
  assign tmds_ch0 = g_ch[0].tmds_q;
  assign tmds_ch1 = g_ch[1].tmds_q;
  assign tmds_ch2 = g_ch[2].tmds_q;
endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// tb_dvi_tmds_encoder: scoreboard bench for dvi_tmds_encoder; expected symbols and disparity come
// from an independent TMDS model or literal values, queued at drive time and popped at output time.
module tb_dvi_tmds_encoder;
`ifdef DVI_ENC_INPUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  logic       pixel_clk, reset_n, de, hsync, vsync;
  logic [7:0] r, g, b;
  logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
  int checks = 0, failures = 0;
  int k0 = 0, k1 = 0, k2 = 0;
  typedef struct {
    logic [9:0] s0, s1, s2;
    int         k0, k1, k2;
  } entry_t;
  entry_t sb[$];

  dvi_tmds_encoder #(.CNT_W(5)) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .de(de), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [7:0] dd, input logic [1:0] c, input logic en, input int k,
                       output logic [9:0] q, output int kn);
    int n1, n0;
    logic [8:0] m;
    logic xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(dd[i]);
    xn = n1 > 4 || (n1 == 4 && dd[0] == 1'b0);
    m[0] = dd[0];
    for (int i = 1; i < 8; i++) m[i] = xn ? ~(m[i-1] ^ dd[i]) : (m[i-1] ^ dd[i]);
    m[8] = ~xn;
    n1 = 0;
    for (int i = 0; i < 8; i++) n1 += int'(m[i]);
    n0 = 8 - n1;
    if (!en) begin
      case (c)
        2'b00: q = 10'h354;
        2'b01: q = 10'h0AB;
        2'b10: q = 10'h154;
        default: q = 10'h2AB;
      endcase
      kn = 0;
    end else if (k == 0 || n1 == n0) begin
      q  = {~m[8], m[8], m[8] ? m[7:0] : ~m[7:0]};
      kn = m[8] ? k + n1 - n0 : k + n0 - n1;
    end else if ((k > 0 && n1 > n0) || (k < 0 && n0 > n1)) begin
      q  = {1'b1, m[8], ~m[7:0]};
      kn = k + 2 * int'(m[8]) + n0 - n1;
    end else begin
      q  = {1'b0, m[8], m[7:0]};
      kn = k + n1 - n0 - (m[8] ? 0 : 2);
    end
  endtask

  task automatic step(input logic rn, e, hs, vs, input logic [7:0] rr, gg, bb,
                      input bit lit, input logic [9:0] l0, l1, l2);
    entry_t x;
    int c0, c1, c2;
    @(negedge pixel_clk);
    if (sb.size() == LAT) begin
      x  = sb.pop_front();
      c0 = int'(dut.g_ch[0].cnt_q);
      c1 = int'(dut.g_ch[1].cnt_q);
      c2 = int'(dut.g_ch[2].cnt_q);
      check($sformatf("ch0@%0t", $time), 32'(tmds_ch0), 32'(x.s0));
      check($sformatf("ch1@%0t", $time), 32'(tmds_ch1), 32'(x.s1));
      check($sformatf("ch2@%0t", $time), 32'(tmds_ch2), 32'(x.s2));
      check($sformatf("cnt0@%0t", $time), c0, x.k0);
      check($sformatf("cnt1@%0t", $time), c1, x.k1);
      check($sformatf("cnt2@%0t", $time), c2, x.k2);
      check($sformatf("cnt_range@%0t", $time),
            32'(c0 >= -10 && c0 <= 10 && c1 >= -10 && c1 <= 10 && c2 >= -10 && c2 <= 10), 32'd1);
    end
    reset_n = rn; de = e; hsync = hs; vsync = vs; r = rr; g = gg; b = bb;
    if (!rn) begin
      sb.delete();
      k0 = 0; k1 = 0; k2 = 0;
      x = '{s0: 10'h354, s1: 10'h354, s2: 10'h354, k0: 0, k1: 0, k2: 0};
      repeat (LAT) sb.push_back(x);
    end else begin
      model(bb, {vs, hs}, e, k0, x.s0, k0);
      model(gg, 2'b00, e, k1, x.s1, k1);
      model(rr, 2'b00, e, k2, x.s2, k2);
      x.k0 = k0; x.k1 = k1; x.k2 = k2;
      if (lit) begin
        x.s0 = l0; x.s1 = l1; x.s2 = l2;
      end
      sb.push_back(x);
    end
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom_range(0, 9) != 0, 1'($urandom), 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom), 1'b0, '0, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0; de = 1'b0; hsync = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0, '0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56, 1'b1, 10'h354, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h0AB, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 10'h154, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 10'h2AB, 10'h354, 10'h354);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h354, 10'h354, 10'h354);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 10'h100, 10'h100, 10'h200);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 10'h3FF, 10'h3FF, 10'h0FF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h354, 10'h354, 10'h354);
    burst(120);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A, 8'hC3, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 10'h100, 10'h100, 10'h100);
    burst(120);
    repeat (LAT + 1) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
